// File: rtl/sme_feeder.sv
// Collects string/pattern records from a byte stream, replays them to a regex matcher
// with framing strobes, then hands the matcher's verdict back over a valid/ready port.
module sme_feeder #(
  parameter int STR_MAX = 32,
  parameter int PAT_MAX = 10
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       s_valid,
  output logic       s_ready,
  input  logic [7:0] s_data,
  input  logic       s_is_pat,
  input  logic       s_last,
  output logic [7:0] sme_chardata,
  output logic       sme_isstring,
  output logic       sme_ispattern,
  input  logic       sme_match,
  input  logic [4:0] sme_match_index,
  input  logic       sme_valid,
  output logic       r_valid,
  input  logic       r_ready,
  output logic       r_match,
  output logic [4:0] r_index,
  output logic       err
);

  localparam int BMAX = (STR_MAX > PAT_MAX) ? STR_MAX : PAT_MAX;
  localparam int LW   = $clog2(BMAX + 1);
  localparam int SW   = (STR_MAX > 1) ? $clog2(STR_MAX) : 1;
  localparam int PW   = (PAT_MAX > 1) ? $clog2(PAT_MAX) : 1;
  localparam logic [LW-1:0] STR_LIM = LW'(STR_MAX);
  localparam logic [LW-1:0] PAT_LIM = LW'(PAT_MAX);

  typedef enum logic [2:0] {COLLECT, SEND_STR, SEND_PAT, GAP, WAIT, RESULT} state_t;

  state_t        state;
  logic [7:0]    str_buf [STR_MAX];
  logic [7:0]    pat_buf [PAT_MAX];
  logic [LW-1:0] wr_ptr, str_len, pat_len, idx;
  logic          in_rec, cur_pat, str_new;

  logic          accept, beat_pat, fits;
  logic [LW-1:0] wp, wp_next;

  // Record type and write slot for the current beat; the type is only taken from the first beat.
  always_comb begin
    accept   = s_valid && s_ready;
    beat_pat = in_rec ? cur_pat : s_is_pat;
    wp       = in_rec ? wr_ptr : '0;
    fits     = beat_pat ? (wp < PAT_LIM) : (wp < STR_LIM);
    wp_next  = fits ? wp + LW'(1) : wp;
  end

  // Buffer storage carries no reset: the lengths alone say which bytes are valid.
  always_ff @(posedge clk) begin
    if (accept && fits && !beat_pat) str_buf[wp[SW-1:0]] <= s_data;
    if (accept && fits && beat_pat)  pat_buf[wp[PW-1:0]] <= s_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= COLLECT;
      wr_ptr        <= '0;
      str_len       <= '0;
      pat_len       <= '0;
      idx           <= '0;
      in_rec        <= 1'b0;
      cur_pat       <= 1'b0;
      str_new       <= 1'b0;
      err           <= 1'b0;
      s_ready       <= 1'b0;
      sme_chardata  <= '0;
      sme_isstring  <= 1'b0;
      sme_ispattern <= 1'b0;
      r_valid       <= 1'b0;
      r_match       <= 1'b0;
      r_index       <= '0;
    end else begin
      case (state)
        COLLECT: begin
          s_ready <= 1'b1;
          if (accept) begin
            if (!fits) err <= 1'b1;
            if (!in_rec) begin
              cur_pat <= s_is_pat;
              if (!s_is_pat) begin
                str_len <= '0;
                str_new <= 1'b1;
              end
            end
            if (s_last) begin
              in_rec <= 1'b0;
              wr_ptr <= '0;
              if (beat_pat) begin
                pat_len <= wp_next;
                s_ready <= 1'b0;
                idx     <= LW'(1);
                // A one-byte pattern is still in flight on s_data this cycle.
                if (str_new) begin
                  state        <= SEND_STR;
                  sme_isstring <= 1'b1;
                  sme_chardata <= str_buf[0];
                end else begin
                  state         <= SEND_PAT;
                  sme_ispattern <= 1'b1;
                  sme_chardata  <= in_rec ? pat_buf[0] : s_data;
                end
              end else begin
                str_len <= wp_next;
              end
            end else begin
              in_rec <= 1'b1;
              wr_ptr <= wp_next;
            end
          end
        end
        SEND_STR: begin
          if (idx < str_len) begin
            sme_chardata <= str_buf[idx[SW-1:0]];
            idx          <= idx + LW'(1);
          end else begin
            str_new       <= 1'b0;
            state         <= SEND_PAT;
            sme_isstring  <= 1'b0;
            sme_ispattern <= 1'b1;
            sme_chardata  <= pat_buf[0];
            idx           <= LW'(1);
          end
        end
        SEND_PAT: begin
          if (idx < pat_len) begin
            sme_chardata <= pat_buf[idx[PW-1:0]];
            idx          <= idx + LW'(1);
          end else begin
            state         <= GAP;
            sme_ispattern <= 1'b0;
            sme_chardata  <= '0;
          end
        end
        GAP: state <= WAIT;
        WAIT: begin
          if (sme_valid) begin
            r_match <= sme_match;
            r_index <= sme_match_index;
            r_valid <= 1'b1;
            state   <= RESULT;
          end
        end
        RESULT: begin
          if (r_ready) begin
            r_valid <= 1'b0;
            pat_len <= '0;
            s_ready <= 1'b1;
            state   <= COLLECT;
          end
        end
        default: state <= COLLECT;
      endcase
    end
  end

endmodule

// File: tb/tb_sme_feeder.sv
// Scoreboard bench for sme_feeder: a record-level model queues the expected matcher
// stream and results; negedge monitors pop and compare whatever the DUT presents.
module tb_sme_feeder;

  localparam int STR_MAX = 32;
  localparam int PAT_MAX = 10;

  typedef logic [7:0] bq_t [$];

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       s_valid = 1'b0;
  logic       s_ready;
  logic [7:0] s_data = '0;
  logic       s_is_pat = 1'b0;
  logic       s_last = 1'b0;
  logic [7:0] sme_chardata;
  logic       sme_isstring, sme_ispattern;
  logic       sme_match = 1'b0;
  logic [4:0] sme_match_index = '0;
  logic       sme_valid = 1'b0;
  logic       r_valid;
  logic       r_ready = 1'b0;
  logic       r_match;
  logic [4:0] r_index;
  logic       err;

  sme_feeder #(.STR_MAX(STR_MAX), .PAT_MAX(PAT_MAX)) dut (
    .clk(clk), .reset_n(reset_n),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_is_pat(s_is_pat), .s_last(s_last),
    .sme_chardata(sme_chardata), .sme_isstring(sme_isstring), .sme_ispattern(sme_ispattern),
    .sme_match(sme_match), .sme_match_index(sme_match_index), .sme_valid(sme_valid),
    .r_valid(r_valid), .r_ready(r_ready), .r_match(r_match), .r_index(r_index), .err(err)
  );

  always #5 clk = ~clk;

  logic [8:0] exp_bytes [$];
  logic [5:0] exp_res [$];
  int         checks = 0;
  int         passes = 0;
  int         str_cycles = 0;
  int         pat_cycles = 0;
  int         model_s_cnt = 0;
  int         model_p_cnt = 0;
  bit         model_str_new = 1'b0;
  bit         model_err = 1'b0;
  bq_t        model_str;
  logic [8:0] mon_e;
  logic [5:0] mon_r;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic failNow(input string name, input string msg);
    checks++;
    $display("[TB] FAIL %s: %s", name, msg);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Stream monitor: every strobe cycle must match the next queued byte, idle cycles carry zero.
  always @(negedge clk) begin
    if (sme_isstring || sme_ispattern) begin
      if (sme_isstring) str_cycles++;
      if (sme_ispattern) pat_cycles++;
      check("strobe_exclusive", 32'(sme_isstring && sme_ispattern), 32'(0));
      if (exp_bytes.size() == 0) begin
        failNow("stream_extra", $sformatf("unexpected byte 0x%0h with no expected entry", sme_chardata));
      end else begin
        mon_e = exp_bytes.pop_front();
        check("stream_byte", 32'({sme_isstring, sme_ispattern, sme_chardata}),
              32'({~mon_e[8], mon_e[8], mon_e[7:0]}));
      end
    end else begin
      check("idle_chardata", 32'(sme_chardata), 32'(0));
    end
    if (r_valid && r_ready) begin
      if (exp_res.size() == 0) begin
        failNow("result_extra", "handshake with no expected result");
      end else begin
        mon_r = exp_res.pop_front();
        check("result", 32'({r_match, r_index}), 32'(mon_r));
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic strToQ(input string s, output bq_t q);
    q = {};
    for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
  endtask

  task automatic randBytes(input int n, output bq_t q);
    q = {};
    for (int i = 0; i < n; i++) q.push_back(8'($urandom_range(32, 126)));
  endtask

  task automatic modelString(input bq_t q);
    model_str = {};
    foreach (q[i]) begin
      if (i < STR_MAX) model_str.push_back(q[i]);
      else model_err = 1'b1;
    end
    model_str_new = 1'b1;
  endtask

  task automatic modelPattern(input bq_t q);
    model_s_cnt = 0;
    model_p_cnt = 0;
    if (model_str_new) begin
      foreach (model_str[i]) exp_bytes.push_back({1'b0, model_str[i]});
      model_s_cnt = model_str.size();
    end
    foreach (q[i]) begin
      if (i < PAT_MAX) begin
        exp_bytes.push_back({1'b1, q[i]});
        model_p_cnt++;
      end else begin
        model_err = 1'b1;
      end
    end
    model_str_new = 1'b0;
  endtask

  task automatic applyStimulus(input bq_t q, input bit is_pat);
    bit accepted;
    for (int i = 0; i < q.size(); i++) begin
      if ($urandom_range(0, 3) == 0) step();
      s_valid  = 1'b1;
      s_data   = q[i];
      s_is_pat = (i == 0) ? is_pat : ~is_pat;
      s_last   = (i == q.size() - 1);
      accepted = 1'b0;
      for (int w = 0; w < 200 && !accepted; w++) begin
        @(negedge clk);
        accepted = s_ready;
        step();
      end
      s_valid = 1'b0;
      s_last  = 1'b0;
      s_data  = 8'($urandom);
      if (!accepted) begin
        failNow("s_ready_timeout", "byte never accepted");
        return;
      end
    end
  endtask

  task automatic sendString(input bq_t q);
    modelString(q);
    applyStimulus(q, 1'b0);
  endtask

  task automatic sendPattern(input bq_t q);
    str_cycles = 0;
    pat_cycles = 0;
    modelPattern(q);
    applyStimulus(q, 1'b1);
    check("first_strobe_latency", 32'(sme_isstring || sme_ispattern), 32'(1));
  endtask

  // Plays the matcher, then drains the result while checking it is held steady.
  task automatic checkOutput(input bit m, input logic [4:0] ix, input int hold,
                             input bit gap_junk, input bit result_junk);
    int n;
    n = 0;
    while ((sme_isstring || sme_ispattern) && n < 100) begin
      step();
      n++;
    end
    if (n >= 100) failNow("stream_timeout", "strobes never dropped");
    check("stream_drained", 32'(exp_bytes.size()), 32'(0));
    check("isstring_cycles", 32'(str_cycles), 32'(model_s_cnt));
    check("ispattern_cycles", 32'(pat_cycles), 32'(model_p_cnt));
    if (gap_junk) begin
      sme_valid = 1'b1;
      sme_match = ~m;
      sme_match_index = ~ix;
    end
    step();
    sme_valid = 1'b0;
    repeat ($urandom_range(0, 2)) step();
    sme_valid = 1'b1;
    sme_match = m;
    sme_match_index = ix;
    exp_res.push_back({m, ix});
    step();
    sme_valid = 1'b0;
    sme_match = 1'($urandom);
    sme_match_index = 5'($urandom);
    check("r_valid_rise", 32'(r_valid), 32'(1));
    for (int h = 0; h < hold; h++) begin
      if (result_junk && h == hold / 2) begin
        sme_valid = 1'b1;
        sme_match = ~m;
        sme_match_index = ~ix;
      end
      step();
      sme_valid = 1'b0;
      check("hold_r_valid", 32'(r_valid), 32'(1));
      check("hold_result", 32'({r_match, r_index}), 32'({m, ix}));
      check("hold_s_ready", 32'(s_ready), 32'(0));
    end
    r_ready = 1'b1;
    step();
    r_ready = 1'b0;
    check("r_valid_drop", 32'(r_valid), 32'(0));
    check("result_consumed", 32'(exp_res.size()), 32'(0));
    check("s_ready_after_result", 32'(s_ready), 32'(1));
    check("err_flag", 32'(err), 32'(model_err));
  endtask

  task automatic doReset();
    reset_n   = 1'b0;
    s_valid   = 1'b0;
    s_last    = 1'b0;
    sme_valid = 1'b0;
    r_ready   = 1'b0;
    exp_bytes.delete();
    exp_res.delete();
    model_str_new = 1'b0;
    model_err     = 1'b0;
    #1;
    check("rst_strobes", 32'({sme_isstring, sme_ispattern}), 32'(0));
    check("rst_chardata", 32'(sme_chardata), 32'(0));
    check("rst_s_ready", 32'(s_ready), 32'(0));
    check("rst_result", 32'({r_valid, r_match, r_index}), 32'(0));
    check("rst_err", 32'(err), 32'(0));
    step();
    step();
    reset_n = 1'b1;
    step();
    check("s_ready_after_release", 32'(s_ready), 32'(1));
  endtask

  initial begin
    bq_t q, q2;
    int  n;
    $display("[TB] starting sme_feeder bench");
    doReset();

    strToQ("abc ab", q); sendString(q);
    strToQ("ab", q);     sendPattern(q);
    checkOutput(1'b1, 5'd0, 3, 1'b1, 1'b0);
    check("basic_isstring_6", 32'(str_cycles), 32'(6));
    check("basic_ispattern_2", 32'(pat_cycles), 32'(2));

    strToQ("^c$", q); sendPattern(q);
    checkOutput(1'b0, 5'd17, 1, 1'b0, 1'b0);
    check("reuse_isstring_0", 32'(str_cycles), 32'(0));
    check("reuse_ispattern_3", 32'(pat_cycles), 32'(3));

    strToQ("xx", q);    sendString(q);
    strToQ("hello", q); sendString(q);
    strToQ("lo", q);    sendPattern(q);
    checkOutput(1'b1, 5'd3, 2, 1'b1, 1'b0);
    check("last_string_isstring_5", 32'(str_cycles), 32'(5));

    strToQ("z", q); sendString(q);
    sendPattern(q);
    checkOutput(1'b1, 5'd0, 0, 1'b0, 1'b0);
    randBytes(STR_MAX, q); sendString(q);
    randBytes(PAT_MAX, q); sendPattern(q);
    checkOutput(1'b0, 5'd31, 1, 1'b0, 1'b0);
    check("full_no_err", 32'(err), 32'(0));

    strToQ("abcd", q); sendString(q);
    strToQ("c", q);    sendPattern(q);
    checkOutput(1'b1, 5'd2, 20, 1'b1, 1'b1);

    randBytes(34, q);  sendString(q);
    randBytes(12, q2); sendPattern(q2);
    checkOutput(1'b1, 5'd9, 2, 1'b0, 1'b0);
    check("overflow_str_32", 32'(str_cycles), 32'(32));
    check("overflow_pat_10", 32'(pat_cycles), 32'(10));
    check("overflow_err", 32'(err), 32'(1));
    strToQ("q", q); sendPattern(q);
    checkOutput(1'b0, 5'd4, 1, 1'b0, 1'b0);
    check("err_sticky", 32'(err), 32'(1));

    strToQ("abcdef", q); sendString(q);
    strToQ("de", q);     sendPattern(q);
    step();
    step();
    doReset();
    strToQ("abcdef", q); sendString(q);
    strToQ("de", q);     sendPattern(q);
    checkOutput(1'b1, 5'd3, 1, 1'b0, 1'b0);
    check("after_reset_isstring_6", 32'(str_cycles), 32'(6));

    for (int t = 0; t < 15; t++) begin
      n = $urandom_range(0, 2);
      for (int k = 0; k < n; k++) begin
        if ($urandom_range(0, 7) == 0) randBytes(STR_MAX + $urandom_range(1, 3), q);
        else randBytes($urandom_range(1, STR_MAX), q);
        sendString(q);
      end
      if ($urandom_range(0, 7) == 0) randBytes(PAT_MAX + $urandom_range(1, 3), q);
      else randBytes($urandom_range(1, PAT_MAX), q);
      sendPattern(q);
      checkOutput(1'($urandom), 5'($urandom), $urandom_range(0, 3),
                  1'($urandom), 1'($urandom));
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/sme_feeder.md
SME_FEEDER -- requirements
Module: sme_feeder

Interface
REQ-001 Parameter STR_MAX, default 32, string buffer depth in bytes.
REQ-002 Parameter PAT_MAX, default 10, pattern buffer depth in bytes, including ^ and $.
REQ-003 Port clk  in  1  single clock; all logic on rising edge.
REQ-004 Port reset_n  in  1  asynchronous, active-low reset.
REQ-005 Port s_valid  in  1  upstream byte valid.
REQ-006 Port s_ready  out  1  upstream byte accepted when s_valid & s_ready.
REQ-007 Port s_data  in  8  record byte, ASCII.
REQ-008 Port s_is_pat  in  1  record type: 1 = pattern, 0 = string; sampled on the first beat of a record only.
REQ-009 Port s_last  in  1  final byte of the current record.
REQ-010 Port sme_chardata  out  8  byte to the matcher.
REQ-011 Port sme_isstring / sme_ispattern  out  1 each  matcher framing strobes; never both high.
REQ-012 Port sme_match  in  1  matcher result.
REQ-013 Port sme_match_index  in  5  matcher result.
REQ-014 Port sme_valid  in  1  matcher result qualifier.
REQ-015 Port r_valid / r_ready  out / in  1 each  result handshake.
REQ-016 Port r_match  out  1  captured result.
REQ-017 Port r_index  out  5  captured result.
REQ-018 Port err  out  1  sticky overflow flag.

Function
REQ-019 FSM states: COLLECT, SEND_STR, SEND_PAT, GAP, WAIT, RESULT; reset state is COLLECT.
REQ-020 s_ready is 1 only in COLLECT and 0 in every other state.
REQ-021 An accepted beat is written to the string or pattern buffer per the latched type; the write pointer increments; s_last closes the record and stores its length.
REQ-022 A new string record clears the old string length on its first beat and sets flag str_new.
REQ-023 Bytes beyond STR_MAX or PAT_MAX are dropped and set err; err clears only on reset.
REQ-024 Closing a pattern record moves COLLECT -> SEND_STR if str_new, else -> SEND_PAT; closing a string record stays in COLLECT.
REQ-025 If the first byte of a string record is accepted while str_new is already set, the string buffer is overwritten; only the last string is sent.
REQ-026 SEND_STR drives one string byte per cycle with sme_isstring=1, in order from index 0 to len-1, then clears str_new and moves to SEND_PAT with no bubble cycle.
REQ-027 SEND_PAT drives one pattern byte per cycle with sme_ispattern=1, in order, then moves to GAP.
REQ-028 GAP lasts exactly one cycle with both strobes at 0, then moves to WAIT.
REQ-029 Outside SEND_STR/SEND_PAT, sme_isstring=sme_ispattern=0 and sme_chardata=0.
REQ-030 Latency: the first strobe cycle is the cycle after the closing pattern beat is accepted.
REQ-031 WAIT samples sme_valid on each rising edge; when it is 1, sme_match and sme_match_index are captured into r_match and r_index, and the FSM moves to RESULT.
REQ-032 RESULT holds r_valid=1 with r_match and r_index stable until r_valid & r_ready, then returns to COLLECT with the pattern buffer length cleared.
REQ-033 r_ready is ignored outside RESULT; an sme_valid pulse arriving outside WAIT is ignored.
REQ-034 A pattern with no new string since the last result reuses the matcher-held string; only the pattern is sent.
REQ-035 Pattern lengths 1..PAT_MAX and string lengths 1..STR_MAX are all legal; a 1-byte record is closed by a single beat carrying s_last=1.

Reset
REQ-036 Asserting reset_n=0 at any time, including mid-send or in WAIT, immediately forces COLLECT and clears all pointers, lengths, str_new and err.
REQ-037 While reset is asserted: s_ready=0, strobes=0, sme_chardata=0, r_valid=0, r_match=0, r_index=0.
REQ-038 Buffer contents are not reset; lengths alone define validity.
REQ-039 After reset release, s_ready=1 from the first rising edge.

Verification
REQ-040 String "abc ab" then pattern "ab" -> isstring for 6 cycles, then ispattern for 2 cycles, GAP 1 cycle; model sme_valid with match=1, index=0 -> r_valid=1, r_match=1, r_index=0, held until r_ready.
REQ-041 Second pattern "^c$" with no string -> no isstring cycles; ispattern for 3 cycles; result passes through unchanged.
REQ-042 Two string records "xx" then "hello" before pattern "lo" -> only "hello" is sent, 5 isstring cycles.
REQ-043 Send a 34-byte string and then a 12-byte pattern -> 32 and 10 bytes are sent, err=1, and it stays 1 after the next result.
REQ-044 Hold r_ready=0 for 20 cycles in RESULT -> s_ready=0, r_* stable throughout; an sme_valid pulse in RESULT does not alter r_*.
REQ-045 Pulse reset_n low during the 3rd SEND_STR cycle -> strobes drop immediately and s_ready=1 after release; a fresh string+pattern then completes normally.
